// File: rtl/vx_core_req_bank_arb.sv
// vx_core_req_bank_arb: round-robin, line-merging core-to-bank request arbiter.
// Define VX_BANK_ARB_PERF_EN to add the bank_stalls counter port.
module vx_core_req_bank_arb #(
  parameter int NUM_REQS         = 4,
  parameter int NUM_BANKS        = 4,
  parameter int NUM_PORTS        = 1,
  parameter int WORD_SIZE        = 4,
  parameter int LINE_SIZE        = 64,
  parameter int WORD_ADDR_WIDTH  = 30,
  parameter int TAG_WIDTH        = 3,
  parameter int BANK_ADDR_OFFSET = 0,
  parameter int PERF_CTR_BITS    = 44,
  localparam int WSEL_BITS = $clog2(LINE_SIZE / WORD_SIZE),
  localparam int BANK_BITS = $clog2(NUM_BANKS),
  localparam int BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1,
  localparam int LINE_ADDR_WIDTH =
    WORD_ADDR_WIDTH - WSEL_BITS - BANK_BITS,
  localparam int REQS_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic i_clk,
  input  logic i_reset,

  input  logic [NUM_REQS-1:0] i_core_req_valid,
  input  logic [NUM_REQS-1:0] i_core_req_rw,
  input  logic [NUM_REQS-1:0][WORD_ADDR_WIDTH-1:0] i_core_req_addr,
  input  logic [NUM_REQS-1:0][WORD_SIZE-1:0] i_core_req_byteen,
  input  logic [NUM_REQS-1:0][8*WORD_SIZE-1:0] i_core_req_data,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0] i_core_req_tag,
  output logic [NUM_REQS-1:0] o_core_req_ready,

  output logic [NUM_BANKS-1:0] o_per_bank_core_req_valid,
  output logic [NUM_BANKS-1:0] o_per_bank_core_req_rw,
  output logic [NUM_BANKS-1:0][LINE_ADDR_WIDTH-1:0]
    o_per_bank_core_req_addr,
  output logic [NUM_BANKS-1:0][NUM_PORTS-1:0]
    o_per_bank_core_req_pmask,
  output logic [NUM_BANKS-1:0][NUM_PORTS-1:0][WSEL_BITS-1:0]
    o_per_bank_core_req_wsel,
  output logic [NUM_BANKS-1:0][NUM_PORTS-1:0][WORD_SIZE-1:0]
    o_per_bank_core_req_byteen,
  output logic [NUM_BANKS-1:0][NUM_PORTS-1:0][8*WORD_SIZE-1:0]
    o_per_bank_core_req_data,
  output logic [NUM_BANKS-1:0][NUM_PORTS-1:0][REQS_BITS-1:0]
    o_per_bank_core_req_tid,
  output logic [NUM_BANKS-1:0][NUM_PORTS-1:0][TAG_WIDTH-1:0]
    o_per_bank_core_req_tag,
  input  logic [NUM_BANKS-1:0] i_per_bank_core_req_ready
`ifdef VX_BANK_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] o_bank_stalls
`endif
);

  logic [NUM_REQS-1:0][WSEL_BITS-1:0]       w_wsel;
  logic [NUM_REQS-1:0][BSEL_W-1:0]          w_bid;
  logic [NUM_REQS-1:0][LINE_ADDR_WIDTH-1:0] w_line;

  logic [NUM_BANKS-1:0]                w_slot_free;
  logic [NUM_BANKS-1:0]                w_has_grant;
  logic [NUM_BANKS-1:0][NUM_REQS-1:0]  w_grant;
  logic [NUM_BANKS-1:0][REQS_BITS-1:0] w_leader;
  logic [NUM_BANKS-1:0][REQS_BITS-1:0] w_next_ptr;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0] w_pmask;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0][REQS_BITS-1:0] w_slot_lane;

  logic [NUM_BANKS-1:0]                r_valid;
  logic [NUM_BANKS-1:0]                r_rw;
  logic [NUM_BANKS-1:0][REQS_BITS-1:0] r_rr_ptr;
  logic [NUM_BANKS-1:0][LINE_ADDR_WIDTH-1:0] r_addr;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0] r_pmask;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0][WSEL_BITS-1:0]   r_wsel;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0][WORD_SIZE-1:0]   r_byteen;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0][8*WORD_SIZE-1:0] r_data;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0][REQS_BITS-1:0]   r_tid;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0][TAG_WIDTH-1:0]   r_tag;

  // Split each word address into word select, bank id and line address
  // (the bank field is squeezed out of the line address).
  always_comb begin
    w_wsel = '0;
    w_bid  = '0;
    w_line = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_wsel[i] = i_core_req_addr[i][WSEL_BITS-1:0];
      for (int j = 0; j < BANK_BITS; j++) begin
        w_bid[i][j] =
          i_core_req_addr[i][WSEL_BITS+BANK_ADDR_OFFSET+j];
      end
      for (int k = 0; k < LINE_ADDR_WIDTH; k++) begin
        if (k < BANK_ADDR_OFFSET) begin
          w_line[i][k] = i_core_req_addr[i][WSEL_BITS+k];
        end else begin
          w_line[i][k] =
            i_core_req_addr[i][WSEL_BITS+BANK_BITS+k];
        end
      end
    end
  end

  // Per bank: pick the leader from rr_ptr onward, then merge same-line,
  // same-direction candidates into still-empty port slots.
  always_comb begin
    int l;
    logic [LINE_ADDR_WIDTH-1:0] ld_line;
    logic ld_rw;
    l           = 0;
    ld_line     = '0;
    ld_rw       = 1'b0;
    w_slot_free = '0;
    w_has_grant = '0;
    w_grant     = '0;
    w_leader    = '0;
    w_next_ptr  = '0;
    w_pmask     = '0;
    w_slot_lane = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_slot_free[b] =
        !r_valid[b] || i_per_bank_core_req_ready[b];
      w_next_ptr[b] = r_rr_ptr[b];
      ld_line = '0;
      ld_rw   = 1'b0;
      for (int k = 0; k < NUM_REQS; k++) begin
        l = (int'(r_rr_ptr[b]) + k) % NUM_REQS;
        if (i_core_req_valid[l] && (w_bid[l] == BSEL_W'(b))) begin
          if (!w_has_grant[b]) begin
            w_has_grant[b] = 1'b1;
            w_leader[b]    = REQS_BITS'(l);
            w_next_ptr[b]  = REQS_BITS'((l + 1) % NUM_REQS);
            ld_line        = w_line[l];
            ld_rw          = i_core_req_rw[l];
            w_grant[b][l]  = 1'b1;
            w_pmask[b][l % NUM_PORTS]     = 1'b1;
            w_slot_lane[b][l % NUM_PORTS] = REQS_BITS'(l);
          end else if ((w_line[l] == ld_line)
                    && (i_core_req_rw[l] == ld_rw)
                    && !w_pmask[b][l % NUM_PORTS]) begin
            w_grant[b][l]  = 1'b1;
            w_pmask[b][l % NUM_PORTS]     = 1'b1;
            w_slot_lane[b][l % NUM_PORTS] = REQS_BITS'(l);
          end
        end
      end
    end
  end

  // A lane is accepted only when its bank granted it and can take a load.
  always_comb begin
    o_core_req_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_grant[b][i] && w_slot_free[b]) begin
          o_core_req_ready[i] = 1'b1;
        end
      end
    end
  end

  // Output-register control: load on grant, drain when taken, else hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid  <= '0;
      r_pmask  <= '0;
      r_rr_ptr <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_slot_free[b]) begin
          if (w_has_grant[b]) begin
            r_valid[b]  <= 1'b1;
            r_pmask[b]  <= w_pmask[b];
            r_rr_ptr[b] <= w_next_ptr[b];
          end else if (i_per_bank_core_req_ready[b]) begin
            r_valid[b] <= 1'b0;
          end
        end
      end
    end
  end

  // Payload capture; fields of empty slots are left as don't-care.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_slot_free[b] && w_has_grant[b]) begin
        r_rw[b]   <= i_core_req_rw[w_leader[b]];
        r_addr[b] <= w_line[w_leader[b]];
        for (int s = 0; s < NUM_PORTS; s++) begin
          r_wsel[b][s]   <= w_wsel[w_slot_lane[b][s]];
          r_byteen[b][s] <= i_core_req_byteen[w_slot_lane[b][s]];
          r_data[b][s]   <= i_core_req_data[w_slot_lane[b][s]];
          r_tag[b][s]    <= i_core_req_tag[w_slot_lane[b][s]];
          r_tid[b][s]    <= w_slot_lane[b][s];
        end
      end
    end
  end

  assign o_per_bank_core_req_valid  = r_valid;
  assign o_per_bank_core_req_rw     = r_rw;
  assign o_per_bank_core_req_addr   = r_addr;
  assign o_per_bank_core_req_pmask  = r_pmask;
  assign o_per_bank_core_req_wsel   = r_wsel;
  assign o_per_bank_core_req_byteen = r_byteen;
  assign o_per_bank_core_req_data   = r_data;
  assign o_per_bank_core_req_tid    = r_tid;
  assign o_per_bank_core_req_tag    = r_tag;

`ifdef VX_BANK_ARB_PERF_EN
  localparam int CNT_W = REQS_BITS + 1;

  logic [CNT_W-1:0]         w_stall_cnt;
  logic [PERF_CTR_BITS-1:0] r_bank_stalls;

  // Count lanes that are requesting but not accepted this cycle.
  always_comb begin
    w_stall_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (i_core_req_valid[i] && !o_core_req_ready[i]) begin
        w_stall_cnt = w_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Free-running wrap-around stall accumulator.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bank_stalls <= '0;
    end else begin
      r_bank_stalls <= r_bank_stalls + PERF_CTR_BITS'(w_stall_cnt);
    end
  end

  assign o_bank_stalls = r_bank_stalls;
`endif

endmodule

// File: doc/vx_core_req_bank_arb.md
# VX_core_req_bank_arb

Registered, fair successor to the cache core-request bank selector. It decodes each core word request into bank, line address and word select. Per bank, it runs round-robin arbitration among conflicting requests and merges same-line requests onto free bank ports. Grants are held in a per-bank elastic output register, so request fan-in is decoupled from bank pipeline timing. It sits between the core request ports and the cache bank array.

## Interface
- NUM_REQS, 4, core request lanes (>=1)
- NUM_BANKS, 4, banks (power of 2, <= NUM_REQS)
- NUM_PORTS, 1, ports per bank (<= NUM_REQS)
- WORD_SIZE, 4, bytes per word
- LINE_SIZE, 64, bytes per line; WSEL_BITS = log2(LINE_SIZE/WORD_SIZE)
- WORD_ADDR_WIDTH, 30, word address width
- TAG_WIDTH, 3, core tag width
- BANK_ADDR_OFFSET, 0, bank field position above the word-select field
- PERF_CTR_BITS, 44, stall counter width
- Derived widths:
  - BANK_BITS = log2(NUM_BANKS)
  - LINE_ADDR_WIDTH = WORD_ADDR_WIDTH - WSEL_BITS - BANK_BITS
  - REQS_BITS = max(1, clog2(NUM_REQS))
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
- clk in 1 clock
- reset in 1 synchronous active-high reset
- core_req_valid/rw in NUM_REQS each
- core_req_addr in NUM_REQS×WORD_ADDR_WIDTH
- core_req_byteen in NUM_REQS×WORD_SIZE
- core_req_data in NUM_REQS×8·WORD_SIZE
- core_req_tag in NUM_REQS×TAG_WIDTH
- core_req_ready out NUM_REQS, combinational accept
- per_bank_core_req_valid/rw out NUM_BANKS, registered
- per_bank_core_req_addr out NUM_BANKS×LINE_ADDR_WIDTH
- per_bank_core_req_pmask out NUM_BANKS×NUM_PORTS
- per_bank_core_req_wsel/byteen/data/tid/tag out NUM_BANKS×NUM_PORTS×field width
- per_bank_core_req_ready in NUM_BANKS
- bank_stalls out PERF_CTR_BITS; present only with VX_BANK_ARB_PERF_EN

## Operation
- Address decode:
  - wsel = addr[WSEL_BITS-1:0]
  - bid = addr[WSEL_BITS+BANK_ADDR_OFFSET +: BANK_BITS], forced to 0 when NUM_BANKS=1
  - line addr = addr[WSEL_BITS+:] with the bid field removed
- Per bank b:
  - slot_free[b] = !valid_r[b] || per_bank_core_req_ready[b].
  - Candidates are the valid lanes whose bid==b.
  - The leader is the first candidate in cyclic order from rr_ptr[b].
- Merging: a non-leader candidate joins the grant only if all of the following hold:
  - same line addr and same rw as the leader;
  - its port slot (lane % NUM_PORTS) is not yet taken.
  - Slots are filled in cyclic order from rr_ptr[b]; the leader always occupies its own slot.
  - With NUM_PORTS=1, only the leader is granted.
- core_req_ready[i] = lane i is granted in bank bid[i] AND slot_free[bid[i]]. It is independent of core_req_valid[i] for non-candidates (0).
- When a bank has a grant and a free slot:
  - the output register loads valid=1, rw, addr, and pmask (set bits = granted slots);
  - it loads per-slot wsel/byteen/data/tag and tid = lane index;
  - unset-pmask slot fields are don't-care;
  - rr_ptr[b] ← (leader+1) mod NUM_REQS.
- If per_bank_core_req_ready[b] is high and there is no grant, valid_r[b] ← 0.
- If there is no free slot, the register holds and rr_ptr holds.
- Lanes not granted keep their request; the core must hold valid and payload stable until ready.

## Timing
- Reset values: per_bank_core_req_valid=0, pmask=0, rr_ptr=0, bank_stalls=0, core_req_ready=0 (no valid input). Other outputs are don't-care.
- Latency: accept in cycle N → bank output valid in cycle N+1.
- Throughput: one grant per bank per cycle when the bank is ready every cycle. Full-rate back-to-back is required (no bubble).
- Boundary conditions:
  - Output register full with bank not ready: that bank's lanes see ready=0; other banks are unaffected.
  - rr_ptr wraps NUM_REQS-1 → 0.
  - Simultaneous drain and load: the new grant replaces the old entry in the same edge.
  - Reset asserted mid-transfer: held entries are dropped; valid=0 the next cycle.

## Configuration
- VX_BANK_ARB_PERF_EN defined:
  - bank_stalls accumulates each cycle the count of lanes with valid=1 and ready=0;
  - it wraps modulo 2^PERF_CTR_BITS and clears on reset.
- VX_BANK_ARB_PERF_EN undefined: the port and its logic are absent; functional behaviour is identical.

## Test plan
- Defaults, lanes 0–3 valid with addrs 0x00,0x10,0x20,0x30 (bids 0,1,2,3), all banks ready → all ready=1 in cycle 0; cycle 1 every bank valid, tid=lane.
- All 4 lanes hit bank 0, different lines, bank always ready → grants in order 0,1,2,3 over 4 cycles, one per cycle. Restart with lane 0 re-requesting → ptr=0 after wrap, so lane 0 wins.
- NUM_PORTS=2: lanes 0,1 same line in bank 0, both reads → single grant, pmask=2'b11, wsel from each lane. Same test with lane 1 as a write → two cycles.
- Bank 2 ready=0 for 3 cycles with an entry held → lanes to bank 2 ready=0 and output stable. Bank 1 traffic flows. Release → drains, and the next entry appears the following cycle.
- Assert reset with all banks holding entries → next cycle all valid=0, rr_ptr=0.
- With VX_BANK_ARB_PERF_EN: 4 lanes to bank 0 for one cycle → bank_stalls=3 on the next cycle.
